// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
//   Bundles the fetch requester, data requester and memory-port signals of
//   mem_bus_arbiter.
//
//   slave  modport : arbiter side. It takes the requests and memory read data,
//                    and drives the completions and the memory port.
//   master modport : requester/memory side. It is the mirror image of slave.
//
//   Fetch  : if_req, if_addr -> if_ready, if_rdata
//   Data   : d_req, d_we, d_size, d_addr, d_wdata -> d_ready, d_rdata, d_fault
//   Memory : mem_w_en, mem_addr, mem_w_data -> mem_r_data (combinational read)
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_fault;

    logic        mem_w_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        input  mem_r_data,
        output if_ready, if_rdata,
        output d_ready, d_rdata, d_fault,
        output mem_w_en, mem_addr, mem_w_data
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_size, d_addr, d_wdata,
        output mem_r_data,
        input  if_ready, if_rdata,
        input  d_ready, d_rdata, d_fault,
        input  mem_w_en, mem_addr, mem_w_data
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one 32-bit, byte-addressed, word-wide memory port between the
//   instruction-fetch requester and the load/store requester. Data accesses
//   win contested cycles. After STARVE_LIMIT consecutive data grants made
//   while fetch was waiting, the next contested grant goes to fetch.
//   Byte and halfword stores are done as a read-modify-write of the whole
//   word. Misaligned, invalid-size and out-of-range data accesses complete
//   with d_fault and never touch memory.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_bus_arbiter_if.slave. It carries the fetch port
//            (if_req/if_addr/if_ready/if_rdata), the data port
//            (d_req/d_we/d_size/d_addr/d_wdata/d_ready/d_rdata/d_fault) and
//            the memory port (mem_w_en/mem_addr/mem_w_data/mem_r_data).
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [31:0] ADDR_MAX     = 32'h0003_FFFD
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_bus_arbiter_if.slave  bus
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RMW_RD,
        RMW_WR,
        DONE
    } state_t;

    state_t           state_q,     state_d;
    logic             is_data_q,   is_data_d;   // granted requester: 1 = data
    logic             we_q,        we_d;
    logic [1:0]       size_q,      size_d;
    logic [1:0]       off_q,       off_d;       // byte offset within the word
    logic [31:0]      wdata_q,     wdata_d;
    logic [31:0]      buf_q,       buf_d;       // RMW merge buffer
    logic [31:0]      mem_addr_q,  mem_addr_d;
    logic [31:0]      if_rdata_q,  if_rdata_d;
    logic [31:0]      d_rdata_q,   d_rdata_d;
    logic             d_fault_q,   d_fault_d;
    logic [CNT_W-1:0] starve_q,    starve_d;

    logic             if_ready;
    logic             d_ready;
    logic             mem_w_en;
    logic [31:0]      mem_w_data;

    logic             grant_f;
    logic             grant_d;
    logic             d_bad;
    logic [32:0]      d_top;
    logic [31:0]      ld_data;
    logic [31:0]      merged;

    // Last byte address of the word holding d_addr, one bit wider so a word
    // at the very top of the address space cannot wrap past the limit test.
    assign d_top = {1'b0, bus.d_addr[31:2], 2'b00} + 33'd3;

    always_comb begin
        d_bad = 1'b0;
        if (bus.d_size == 2'b11)                          d_bad = 1'b1;
        if (bus.d_size == 2'b01 && bus.d_addr[0])         d_bad = 1'b1;
        if (bus.d_size == 2'b10 && bus.d_addr[1:0] != 0)  d_bad = 1'b1;
        if (d_top > {1'b0, ADDR_MAX})                     d_bad = 1'b1;
    end

    // Load lane select: pick the addressed byte/halfword, zero-extended.
    always_comb begin
        ld_data = bus.mem_r_data;
        case (size_q)
            2'b00: begin
                case (off_q)
                    2'd0:    ld_data = {24'd0, bus.mem_r_data[7:0]};
                    2'd1:    ld_data = {24'd0, bus.mem_r_data[15:8]};
                    2'd2:    ld_data = {24'd0, bus.mem_r_data[23:16]};
                    default: ld_data = {24'd0, bus.mem_r_data[31:24]};
                endcase
            end
            2'b01: begin
                if (off_q[1]) ld_data = {16'd0, bus.mem_r_data[31:16]};
                else          ld_data = {16'd0, bus.mem_r_data[15:0]};
            end
            default: ld_data = bus.mem_r_data;
        endcase
    end

    // Store merge: replace only the addressed lane(s) of the read-back word.
    always_comb begin
        merged = buf_q;
        if (size_q == 2'b00) begin
            case (off_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else begin
            if (off_q[1]) merged[31:16] = wdata_q[15:0];
            else          merged[15:0]  = wdata_q[15:0];
        end
    end

    // Arbitration: data wins unless fetch has been passed over LIMIT times.
    assign grant_f = bus.if_req && (!bus.d_req || starve_q == LIMIT);
    assign grant_d = bus.d_req && !grant_f;

    always_comb begin
        state_d    = state_q;
        is_data_d  = is_data_q;
        we_d       = we_q;
        size_d     = size_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        mem_addr_d = mem_addr_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        d_fault_d  = d_fault_q;
        starve_d   = starve_q;
        if_ready   = 1'b0;
        d_ready    = 1'b0;
        mem_w_en   = 1'b0;
        mem_w_data = 32'd0;

        case (state_q)
            IDLE: begin
                if (grant_f) begin
                    is_data_d  = 1'b0;
                    we_d       = 1'b0;
                    size_d     = 2'b10;
                    off_d      = bus.if_addr[1:0];
                    mem_addr_d = {bus.if_addr[31:2], 2'b00};
                    starve_d   = '0;
                    state_d    = ACCESS;
                end else if (grant_d) begin
                    is_data_d  = 1'b1;
                    we_d       = bus.d_we;
                    size_d     = bus.d_size;
                    off_d      = bus.d_addr[1:0];
                    wdata_d    = bus.d_wdata;
                    mem_addr_d = {bus.d_addr[31:2], 2'b00};
                    if (!bus.if_req)           starve_d = '0;
                    else if (starve_q != LIMIT) starve_d = starve_q + CNT_W'(1);
                    if (d_bad) begin
                        // Rejected accesses complete next cycle, no memory effect.
                        d_fault_d = 1'b1;
                        d_rdata_d = 32'd0;
                        state_d   = DONE;
                    end else if (bus.d_we && !bus.d_size[1]) begin
                        state_d   = RMW_RD;
                    end else begin
                        state_d   = ACCESS;
                    end
                end
            end

            ACCESS: begin
                if (is_data_q) begin
                    d_fault_d = 1'b0;
                    if (we_q) begin
                        mem_w_en   = 1'b1;
                        mem_w_data = wdata_q;
                        d_rdata_d  = 32'd0;
                    end else begin
                        d_rdata_d  = ld_data;
                    end
                end else begin
                    if_rdata_d = bus.mem_r_data;
                end
                state_d = DONE;
            end

            RMW_RD: begin
                buf_d   = bus.mem_r_data;
                state_d = RMW_WR;
            end

            RMW_WR: begin
                mem_w_en   = 1'b1;
                mem_w_data = merged;
                d_fault_d  = 1'b0;
                d_rdata_d  = 32'd0;
                state_d    = DONE;
            end

            DONE: begin
                if (is_data_q) d_ready  = 1'b1;
                else           if_ready = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_data_q  <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            wdata_q    <= 32'd0;
            buf_q      <= 32'd0;
            mem_addr_q <= 32'd0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
            d_fault_q  <= 1'b0;
            starve_q   <= '0;
        end else begin
            is_data_q  <= is_data_d;
            we_q       <= we_d;
            size_q     <= size_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            mem_addr_q <= mem_addr_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            d_fault_q  <= d_fault_d;
            starve_q   <= starve_d;
        end
    end

    // Ready and write enable decode straight from state_q, so an asserted
    // reset removes them immediately rather than at the next edge.
    assign bus.if_ready   = if_ready;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.d_ready    = d_ready;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.d_fault    = d_fault_q;
    assign bus.mem_w_en   = mem_w_en;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_w_data = mem_w_data;

endmodule
